pdm_interp_dac: RTL and testbench

Audio output stage that consumes unsigned PCM samples from the sample sequencer and drives the 1-bit audio PMOD pin. Samples arrive through a valid/ready handshake into a 2-entry FIFO. Each sample is linearly interpolated over 2^INTERP_LOG2 clocks to suppress zero-order-hold steps. The interpolated level is converted to a pulse-density bitstream by a first-order error-feedback modulator.

---
 rtl/pdm_interp_dac.sv | 152 +++++++++++++++
 tb/tb_pdm_interp_dac.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_interp_dac.sv
// PCM-to-PDM audio output: 2-entry sample FIFO, linear interpolation across
// 2^INTERP_LOG2 clocks per sample, then a first-order error-feedback modulator.
module pdm_interp_dac #(
    parameter int N           = 16,
    parameter int INTERP_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic         pdm_out,
    output logic [N-1:0] level,
    output logic         underrun
);
    localparam int AW = N + INTERP_LOG2;
    localparam logic [INTERP_LOG2-1:0] PHASE_LAST = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [N-1:0]           fifo_q [2];
    logic                   rd_ptr_q, wr_ptr_q;
    logic [1:0]             count_q, count_d;
    logic [INTERP_LOG2-1:0] phase_q, phase_d;
    logic [N-1:0]           prev_q, prev_d;
    logic [N-1:0]           cur_q, cur_d;
    logic [AW-1:0]          interp_acc_q, interp_acc_d;
    logic [N-1:0]           level_q, level_d;
    logic                   underrun_q, underrun_d;
    logic [N-1:0]           mod_acc_q;
    logic                   pdm_q;
    logic                   push, pop;
    logic [N-1:0]           head;
    logic [N:0]             diff;
    logic [AW-1:0]          diff_ext;
    logic [N:0]             mod_sum;

    assign sample_ready = (count_q != 2'd2);
    assign push         = sample_valid && sample_ready;
    assign head         = fifo_q[rd_ptr_q];

    // Per-clock slope of the ramp; may be negative, so it is sign-extended.
    assign diff     = {1'b0, cur_q} - {1'b0, prev_q};
    assign diff_ext = AW'($signed(diff));

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sample_in;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        interp_acc_d = interp_acc_q;
        level_d      = '0;
        underrun_d   = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop          = 1'b1;
                    prev_d       = head;
                    cur_d        = head;
                    interp_acc_d = {head, {INTERP_LOG2{1'b0}}};
                    phase_d      = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                level_d = interp_acc_q[AW-1:INTERP_LOG2];
                phase_d = phase_q + 1'b1;
                // Reloading at the boundary keeps rounding error from carrying into the next period.
                if (phase_q == PHASE_LAST) begin
                    interp_acc_d = {cur_q, {INTERP_LOG2{1'b0}}};
                    prev_d       = cur_q;
                    if (count_q != 2'd0) begin
                        pop   = 1'b1;
                        cur_d = head;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    interp_acc_d = interp_acc_q + diff_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            prev_q       <= '0;
            cur_q        <= '0;
            interp_acc_q <= '0;
            level_q      <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            interp_acc_q <= interp_acc_d;
            level_q      <= level_d;
            underrun_q   <= underrun_d;
        end
    end

    // The carry out of the error accumulator is the output bit.
    assign mod_sum = {1'b0, mod_acc_q} + {1'b0, level_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_acc_q <= '0;
            pdm_q     <= 1'b0;
        end else begin
            mod_acc_q <= mod_sum[N-1:0];
            pdm_q     <= mod_sum[N];
        end
    end

    assign pdm_out  = pdm_q;
    assign level    = level_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_interp_dac.sv
// Self-checking bench for pdm_interp_dac: a sample scoreboard feeds a
// behavioural reference that predicts level, pdm_out, underrun and sample_ready.
module tb_pdm_interp_dac;
    localparam int N      = 16;
    localparam int IL     = 4;
    localparam int PERIOD = 1 << IL;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         pdm_out;
    logic [N-1:0] level;
    logic         underrun;

    int tests = 0;
    int fails = 0;
    bit checkOn = 1'b1;

    logic [N-1:0] mq[$];
    bit mRun = 1'b0;
    int mPhase = 0;
    int mPrev = 0;
    int mCur = 0;
    int mAcc = 0;
    int expLevel = 0;
    int expPdm = 0;
    int expUnder = 0;

    pdm_interp_dac #(.N(N), .INTERP_LOG2(IL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdm_out      (pdm_out),
        .level        (level),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: accepted samples queue up, each period ramps linearly from prev to cur.
    always @(posedge clk or negedge rst_n) begin : model
        int sum;
        bit push;
        if (!rst_n) begin
            mq.delete();
            mRun     = 1'b0;
            mPhase   = 0;
            mPrev    = 0;
            mCur     = 0;
            mAcc     = 0;
            expLevel = 0;
            expPdm   = 0;
            expUnder = 0;
        end else begin
            push     = sample_valid && (mq.size() != 2);
            sum      = mAcc + expLevel;
            expPdm   = (sum >> N) & 1;
            mAcc     = sum & ((1 << N) - 1);
            expUnder = 0;
            if (!mRun) begin
                expLevel = 0;
                if (mq.size() > 0) begin
                    mCur   = int'(mq.pop_front());
                    mPrev  = mCur;
                    mPhase = 0;
                    mRun   = 1'b1;
                end
            end else begin
                expLevel = (mPrev * PERIOD + mPhase * (mCur - mPrev)) / PERIOD;
                if (mPhase == PERIOD - 1) begin
                    mPrev = mCur;
                    if (mq.size() > 0) mCur = int'(mq.pop_front());
                    else expUnder = 1;
                    mPhase = 0;
                end else begin
                    mPhase++;
                end
            end
            if (push) mq.push_back(sample_in);
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("level", 32'(level), 32'(expLevel));
            checkOutput("pdm_out", 32'(pdm_out), 32'(expPdm));
            checkOutput("underrun", 32'(underrun), 32'(expUnder));
            checkOutput("sample_ready", 32'(sample_ready), 32'(mq.size() != 2));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] s, input int cycles);
        sample_in    = s;
        sample_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic countWindow(input int cycles, output int ones, output int unders);
        ones   = 0;
        unders = 0;
        repeat (cycles) begin
            @(negedge clk);
            #1;
            ones   += int'(pdm_out);
            unders += int'(underrun);
        end
    endtask

    task automatic doReset(input int cycles);
        #2 rst_n = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            sample_in    = N'($urandom);
            sample_valid = 1'($urandom_range(0, 1));
        end
        #1;
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_pdm", 32'(pdm_out), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_ready", 32'(sample_ready), 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n        = 1'b1;
    endtask

    initial begin
        int ones, unders, stalls, guard;
        bit accepted;
        logic [N-1:0] seq [4];

        // Reset with noisy inputs, then silence.
        doReset(10);
        countWindow(1000, ones, unders);
        checkOutput("idle_ones", 32'(ones), 32'd0);

        // Constant mid-scale: alternating bitstream.
        doReset(3);
        applyStimulus(16'h8000, 8);
        countWindow(16, ones, unders);
        checkOutput("half_ones16", 32'(ones), 32'd8);
        checkOutput("half_level", 32'(level), 32'h8000);

        doReset(3);
        applyStimulus(16'h0000, 4);
        countWindow(200, ones, unders);
        checkOutput("zero_ones", 32'(ones), 32'd0);

        doReset(3);
        applyStimulus(16'hFFFF, 4);
        idle(4);
        countWindow(1024, ones, unders);
        checkOutput("full_ones_ge1023", 32'(ones >= 1023), 32'd1);

        // Ramps up and down.
        doReset(3);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'h1000, 1);
        idle(40);
        checkOutput("ramp_up_end", 32'(level), 32'h1000);

        doReset(3);
        applyStimulus(16'h1000, 1);
        applyStimulus(16'h0000, 1);
        idle(40);
        checkOutput("ramp_down_end", 32'(level), 32'h0000);

        // Backpressure with valid held high.
        doReset(3);
        seq[0] = 16'h1000;
        seq[1] = 16'h3000;
        seq[2] = 16'h2000;
        seq[3] = 16'h5000;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            sample_in    = seq[i];
            sample_valid = 1'b1;
            guard        = 0;
            do begin
                accepted = sample_ready;
                if (!accepted) stalls++;
                @(negedge clk);
                guard++;
            end while (!accepted && guard < 100);
            if (!accepted) checkOutput("bp_timeout", 32'd0, 32'd1);
        end
        sample_valid = 1'b0;
        checkOutput("bp_stall_cycles", 32'(stalls), 32'd15);
        idle(100);
        checkOutput("bp_final_level", 32'(level), 32'h5000);

        // Underrun with a single sample, then recovery.
        doReset(3);
        applyStimulus(16'h4000, 1);
        idle(20);
        countWindow(64, ones, unders);
        checkOutput("ur_ones64", 32'(ones), 32'd16);
        checkOutput("ur_pulses64", 32'(unders), 32'd4);
        checkOutput("ur_level", 32'(level), 32'h4000);
        applyStimulus(16'h8000, 1);
        idle(40);
        checkOutput("ur_recover_level", 32'(level), 32'h8000);

        // Asynchronous reset mid-ramp with the FIFO full.
        doReset(3);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'hF000, 30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_level", 32'(level), 32'd0);
        checkOutput("async_pdm", 32'(pdm_out), 32'd0);
        checkOutput("async_underrun", 32'(underrun), 32'd0);
        checkOutput("async_ready", 32'(sample_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            sample_in    = N'($urandom);
            sample_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n        = 1'b1;
        idle(40);
        checkOutput("post_rst_level", 32'(level), 32'd0);
        applyStimulus(16'h2000, 1);
        idle(40);
        checkOutput("post_rst_new_level", 32'(level), 32'h2000);

        checkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
